// File: rtl/lcd_page_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_page_arbiter
//
// Purpose:
//    Shares one two-line 16x2 character LCD between NUM_REQ page requesters.
//    Requesters are served round-robin. Each winner keeps the display for at
//    least DWELL_CYCLES clock cycles. While the owner keeps requesting, its
//    text is copied live into the output buffers. When the owner drops its
//    request, the buffers hold their last contents until the dwell ends.
//
// Parameters:
//    NUM_REQ       number of page requesters (2..8)
//    DWELL_CYCLES  minimum display time per grant in clk_50mhz cycles (>= 2)
//
// Ports:
//    clk_50mhz     single clock, rising edge
//    rst_n         asynchronous, active-low reset
//    req           level request per requester
//    page_line1    line-1 text of every requester, 128 bits each, packed by index
//    page_line2    line-2 text of every requester, same packing
//    grant         one-hot owner of the display, or zero
//    ack           one-cycle pulse to the requester whose page was just latched
//    active_id     index of the most recently granted requester
//    update        one-cycle pulse whenever a new grant is latched
//    line1_buffer  registered line-1 text towards the LCD controller
//    line2_buffer  registered line-2 text towards the LCD controller
// ---------------------------------------------------------------------------
module lcd_page_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic                       clk_50mhz,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*128-1:0]     page_line1,
   input  logic [NUM_REQ*128-1:0]     page_line2,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         ack,
   output logic [$clog2(NUM_REQ)-1:0] active_id,
   output logic                       update,
   output logic [127:0]               line1_buffer,
   output logic [127:0]               line2_buffer
);

   localparam int                ID_W     = $clog2(NUM_REQ);
   localparam int                CNT_W    = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [ID_W-1:0]   ID_RESET = ID_W'(NUM_REQ - 1);
   localparam logic [127:0]      SPACES   = {16{8'h20}};

   typedef enum logic [1:0] {IDLE, SELECT, LATCH, DWELL} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_dwell_cnt;
   logic [ID_W-1:0]      r_active_id;
   logic [NUM_REQ-1:0]   r_ack;
   logic                 r_update;
   logic [127:0]         r_line1;
   logic [127:0]         r_line2;

   logic                 w_any_req;
   logic                 w_found_hi;
   logic [ID_W-1:0]      w_first_hi;
   logic [ID_W-1:0]      w_first_lo;
   logic [ID_W-1:0]      w_next_winner;
   logic [NUM_REQ-1:0]   w_owner_onehot;
   logic                 w_owner_req;
   logic [127:0]         w_owner_line1;
   logic [127:0]         w_owner_line2;

   assign w_any_req      = |req;
   assign w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_active_id;
   assign w_owner_req    = |(req & w_owner_onehot);

   // Round-robin search. Scan requesters from the highest index down to
   // the lowest, so the last match kept is the lowest one. A requester
   // above active_id wins over any requester at or below it. This gives an
   // ascending, wrapping search that starts at active_id+1, and the current
   // owner is found last.
   always_comb begin
      w_first_hi = '0;
      w_first_lo = '0;
      w_found_hi = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            if (ID_W'(j) > r_active_id) begin
               w_first_hi = ID_W'(j);
               w_found_hi = 1'b1;
            end else begin
               w_first_lo = ID_W'(j);
            end
         end
      end
      w_next_winner = w_found_hi ? w_first_hi : w_first_lo;
   end

   // Select the text of the current owner from the packed page buses.
   always_comb begin
      w_owner_line1 = SPACES;
      w_owner_line2 = SPACES;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (r_active_id == ID_W'(j)) begin
            w_owner_line1 = page_line1[128*j +: 128];
            w_owner_line2 = page_line2[128*j +: 128];
         end
      end
   end

   // State register.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. At the end of a dwell, the arbiter either returns to
   // SELECT or goes to IDLE. It decides only when the counter has reached
   // zero, so neither the owner dropping its request nor newcomers
   // arriving can change the dwell length.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_next_state = SELECT;
         SELECT:  w_next_state = w_any_req ? LATCH : IDLE;
         LATCH:   w_next_state = DWELL;
         DWELL: begin
            if (r_dwell_cnt == '0) begin
               w_next_state = w_any_req ? SELECT : IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Output logic. grant is decoded from the state, so it shows the owner
   // only during LATCH and DWELL. It drops as soon as the arbiter leaves
   // the dwell or a reset arrives.
   always_comb begin
      grant = '0;
      if (r_state == LATCH || r_state == DWELL) begin
         grant = w_owner_onehot;
      end
   end

   // Datapath. The winner is stored in active_id when SELECT executes. When
   // LATCH executes, the page is copied, ack and update are pulsed, and the
   // dwell counter is loaded. During DWELL the counter counts down to zero
   // and stops there. The buffers are refreshed only while the owner is
   // still requesting.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_active_id <= ID_RESET;
         r_dwell_cnt <= '0;
         r_ack       <= '0;
         r_update    <= 1'b0;
         r_line1     <= SPACES;
         r_line2     <= SPACES;
      end else begin
         r_ack    <= '0;
         r_update <= 1'b0;
         case (r_state)
            SELECT: begin
               if (w_any_req) begin
                  r_active_id <= w_next_winner;
               end
            end
            LATCH: begin
               r_line1     <= w_owner_line1;
               r_line2     <= w_owner_line2;
               r_ack       <= w_owner_onehot;
               r_update    <= 1'b1;
               r_dwell_cnt <= CNT_LOAD;
            end
            DWELL: begin
               if (r_dwell_cnt != '0) begin
                  r_dwell_cnt <= r_dwell_cnt - CNT_W'(1);
               end
               if (w_owner_req) begin
                  r_line1 <= w_owner_line1;
                  r_line2 <= w_owner_line2;
               end
            end
            default: ;
         endcase
      end
   end

   assign ack          = r_ack;
   assign update       = r_update;
   assign active_id    = r_active_id;
   assign line1_buffer = r_line1;
   assign line2_buffer = r_line2;

endmodule

// File: tb/tb_lcd_page_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_page_arbiter
//
// Purpose:
//    Self-checking bench for lcd_page_arbiter with NUM_REQ=4 and
//    DWELL_CYCLES=8.
//
//    A behavioural model tracks, for each grant, how many clock edges have
//    passed since its selection. From that count it derives the expected
//    grant, ack, update, active_id and buffers. A compare process checks
//    the DUT against the model one time unit after every rising edge.
//    Directed scenarios also check hand-computed literal values at fixed
//    edges.
// ---------------------------------------------------------------------------
module tb_lcd_page_arbiter;

   localparam int NR    = 4;
   localparam int DWELL = 8;
   localparam logic [127:0] SPACES = {16{8'h20}};

   logic              clk_50mhz = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req;
   logic [NR*128-1:0] page_line1;
   logic [NR*128-1:0] page_line2;
   logic [NR-1:0]     grant;
   logic [NR-1:0]     ack;
   logic [1:0]        active_id;
   logic              update;
   logic [127:0]      line1_buffer;
   logic [127:0]      line2_buffer;

   int testsRun  = 0;
   int failCount = 0;
   bit compareOn = 1'b0;

   lcd_page_arbiter #(
      .NUM_REQ      (NR),
      .DWELL_CYCLES (DWELL)
   ) dut (
      .clk_50mhz    (clk_50mhz),
      .rst_n        (rst_n),
      .req          (req),
      .page_line1   (page_line1),
      .page_line2   (page_line2),
      .grant        (grant),
      .ack          (ack),
      .active_id    (active_id),
      .update       (update),
      .line1_buffer (line1_buffer),
      .line2_buffer (line2_buffer)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   // Behavioural model. mSince is the number of edges since the owner was
   // selected, or -1 when nobody is being served. Edge 1 after selection
   // latches the page. Edges 2..DWELL+1 are the dwell. The last of these
   // decides between a new selection and going idle.
   int           mSince;
   bit           mWantSel;
   int           mOwner;
   int           mLast;
   logic [NR-1:0] mAck;
   logic          mUpd;
   logic [127:0]  mLine1;
   logic [127:0]  mLine2;

   function automatic int pickNext(input int last, input logic [NR-1:0] r);
      int pick;
      pick = -1;
      for (int k = 1; k <= NR; k++) begin
         if (pick < 0 && r[(last + k) % NR]) pick = (last + k) % NR;
      end
      return pick;
   endfunction

   always @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         mSince   = -1;
         mWantSel = 1'b0;
         mOwner   = 0;
         mLast    = NR - 1;
         mAck     = '0;
         mUpd     = 1'b0;
         mLine1   = SPACES;
         mLine2   = SPACES;
      end else begin
         mAck = '0;
         mUpd = 1'b0;
         if (mSince >= 0) begin
            mSince++;
            if (mSince == 1) begin
               mLine1 = page_line1[128*mOwner +: 128];
               mLine2 = page_line2[128*mOwner +: 128];
               mAck   = 4'(1) << mOwner;
               mUpd   = 1'b1;
            end else begin
               if (req[mOwner]) begin
                  mLine1 = page_line1[128*mOwner +: 128];
                  mLine2 = page_line2[128*mOwner +: 128];
               end
               if (mSince == DWELL + 1) begin
                  mSince   = -1;
                  mWantSel = (req != '0);
               end
            end
         end else if (mWantSel) begin
            if (req != '0) begin
               mOwner = pickNext(mLast, req);
               mLast  = mOwner;
               mSince = 0;
            end
            mWantSel = 1'b0;
         end else if (req != '0) begin
            mWantSel = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Compare process: every cycle, one time unit after the rising edge.
   always @(posedge clk_50mhz) begin
      #1;
      if (compareOn) begin
         checkOutput("model grant", 128'(grant),
                     (mSince >= 0) ? 128'(4'(1) << mOwner) : 128'(0));
         checkOutput("model ack", 128'(ack), 128'(mAck));
         checkOutput("model update", 128'(update), 128'(mUpd));
         checkOutput("model active_id", 128'(active_id), 128'(mLast));
         checkOutput("model line1", line1_buffer, mLine1);
         checkOutput("model line2", line2_buffer, mLine2);
      end
   end

   task automatic applyStimulus(input logic [NR-1:0] reqVal);
      @(negedge clk_50mhz);
      req = reqVal;
   endtask

   task automatic waitEdge(input int n);
      repeat (n) @(posedge clk_50mhz);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk_50mhz);
      rst_n = 1'b0;
      @(negedge clk_50mhz);
      rst_n = 1'b1;
   endtask

   logic [127:0]  helloText;
   logic [NR-1:0] gTrace [32];
   int            cnt;

   initial begin
      helloText = "Hello World!    ";
      rst_n = 1'b0;
      req   = '0;
      page_line1[0*128 +: 128] = "Page 0 line 1   ";
      page_line1[1*128 +: 128] = "Page 1 line 1   ";
      page_line1[2*128 +: 128] = helloText;
      page_line1[3*128 +: 128] = "Page 3 line 1   ";
      page_line2[0*128 +: 128] = "Page 0 line 2   ";
      page_line2[1*128 +: 128] = "Page 1 line 2   ";
      page_line2[2*128 +: 128] = "Page 2 line 2  0";
      page_line2[3*128 +: 128] = "Page 3 line 2   ";
      repeat (2) @(posedge clk_50mhz);
      compareOn = 1'b1;
      @(negedge clk_50mhz);
      rst_n = 1'b1;

      // Reset state
      waitEdge(2);
      checkOutput("reset line1", line1_buffer, SPACES);
      checkOutput("reset line2", line2_buffer, SPACES);
      checkOutput("reset grant", 128'(grant), 128'(0));
      checkOutput("reset ack", 128'(ack), 128'(0));
      checkOutput("reset update", 128'(update), 128'(0));
      checkOutput("reset active_id", 128'(active_id), 128'(3));

      // Single requester, with live text and then frozen text
      applyStimulus(4'b0100);
      waitEdge(1);
      checkOutput("single grant t", 128'(grant), 128'(0));
      waitEdge(1);
      checkOutput("single grant t+1", 128'(grant), 128'(4'b0100));
      checkOutput("single ack t+1", 128'(ack), 128'(0));
      waitEdge(1);
      checkOutput("single ack t+2", 128'(ack), 128'(4'b0100));
      checkOutput("single update t+2", 128'(update), 128'(1));
      checkOutput("single line1 t+2", line1_buffer, helloText);
      waitEdge(1);
      checkOutput("single update t+3", 128'(update), 128'(0));
      @(negedge clk_50mhz);
      page_line2[2*128 +: 8] = 8'h39;
      waitEdge(1);
      checkOutput("live byte0", 128'(line2_buffer[7:0]), 128'(8'h39));
      checkOutput("live no update", 128'(update), 128'(0));
      @(negedge clk_50mhz);
      req = 4'b0000;
      page_line2[2*128 +: 8] = 8'h35;
      waitEdge(1);
      checkOutput("frozen byte0", 128'(line2_buffer[7:0]), 128'(8'h39));
      checkOutput("frozen grant", 128'(grant), 128'(4'b0100));
      waitEdge(4);
      checkOutput("single grant t+9", 128'(grant), 128'(4'b0100));
      waitEdge(1);
      checkOutput("single grant t+10", 128'(grant), 128'(0));
      page_line2[2*128 +: 8] = 8'h30;

      // Round-robin over requesters 0, 1 and 3, starting from a reset
      doReset();
      applyStimulus(4'b1011);
      for (int k = 0; k < 32; k++) begin
         waitEdge(1);
         gTrace[k] = grant;
      end
      cnt = 0;
      for (int k = 0; k <= 10; k++) if (gTrace[k] == 4'b0001) cnt++;
      checkOutput("rr first grant length", 128'(cnt), 128'(9));
      checkOutput("rr grant t+1", 128'(gTrace[1]), 128'(4'b0001));
      checkOutput("rr gap t+10", 128'(gTrace[10]), 128'(0));
      checkOutput("rr grant t+11", 128'(gTrace[11]), 128'(4'b0010));
      checkOutput("rr gap t+20", 128'(gTrace[20]), 128'(0));
      checkOutput("rr grant t+21", 128'(gTrace[21]), 128'(4'b1000));
      checkOutput("rr grant t+31", 128'(gTrace[31]), 128'(4'b0001));
      applyStimulus(4'b0000);
      waitEdge(12);

      // Late arrival of requester 1 while requester 0 is dwelling
      applyStimulus(4'b0001);
      waitEdge(5);
      applyStimulus(4'b0011);
      waitEdge(1);
      checkOutput("late grant t+5", 128'(grant), 128'(4'b0001));
      waitEdge(4);
      checkOutput("late grant t+9", 128'(grant), 128'(4'b0001));
      waitEdge(2);
      checkOutput("late grant t+11", 128'(grant), 128'(4'b0010));
      waitEdge(1);
      checkOutput("late ack t+12", 128'(ack), 128'(4'b0010));
      applyStimulus(4'b0000);
      waitEdge(12);

      // A sole owner that keeps requesting is granted again, with a fresh ack
      applyStimulus(4'b0100);
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         waitEdge(1);
         if (ack == 4'b0100) cnt++;
      end
      checkOutput("regrant ack count", 128'(cnt), 128'(2));

      // Reset in the middle of a dwell
      @(negedge clk_50mhz);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset line1", line1_buffer, SPACES);
      checkOutput("midreset line2", line2_buffer, SPACES);
      checkOutput("midreset grant", 128'(grant), 128'(0));
      checkOutput("midreset update", 128'(update), 128'(0));
      @(negedge clk_50mhz);
      rst_n = 1'b1;
      req   = 4'b0101;
      waitEdge(1);
      checkOutput("postreset grant t", 128'(grant), 128'(0));
      waitEdge(1);
      checkOutput("postreset grant t+1", 128'(grant), 128'(4'b0001));
      applyStimulus(4'b0000);
      waitEdge(15);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
